stream_buffer: RTL and testbench
================================

# stream_buffer

Elastic FIFO for a primitive stream channel, carrying one `N`-bit stream with valid/ready handshakes on both sides. It sits directly upstream of a stream-consuming primitive such as an `ap0x` splitter, or between two chained primitives. Its purpose is to absorb backpressure so the producer can keep issuing one token per cycle while the consumer stalls. Tokens leave in arrival order, unmodified.

## Interface
Parameters:
- `N`, default 8: token width in bits.
- `DEPTH`, default 4: storage entries. Must be a power of two and ≥ 2.

Ports:
- `clk` input 1: single clock; all state changes on the rising edge.
- `nrst` input 1: reset is asynchronous and active-low.
- `sIn` input N: incoming token.
- `sIn_valid` input 1: `sIn` holds a token this cycle.
- `sIn_ready` output 1: buffer accepts a token this cycle.
- `sOut` output N: head token.
- `sOut_valid` output 1: `sOut` holds a token.
- `sOut_ready` input 1: consumer takes the head this cycle.

## Operation
- Push occurs when `sIn_valid && sIn_ready`. The token is written at `wr_ptr`, then `wr_ptr` increments modulo DEPTH.
- Pop occurs when `sOut_valid && sOut_ready`. `rd_ptr` increments modulo DEPTH.
- Occupancy `count` has width clog2(DEPTH)+1 and ranges 0..DEPTH.
  - Push only: +1.
  - Pop only: −1.
  - Push and pop together, or neither: unchanged.
- `sIn_ready = (count != DEPTH)`. It is decoded from registers only, with no combinational path from `sOut_ready`. When full, a same-cycle pop does not open `sIn_ready`; it rises the following cycle.
- `sOut_valid = (count != 0)`. `sOut` = `mem[rd_ptr]`, read combinationally from the array, so the head is visible as soon as `count` ≥ 1.
- Push and pop together at any level 1..DEPTH−1: both pointers advance and `count` holds.
- When empty: `sOut_valid` = 0 and no pop occurs, even if `sOut_ready` = 1. A token pushed into an empty buffer appears on `sOut` the next cycle; there is no fall-through path.
- Pointer wrap: a pointer at DEPTH−1 goes to 0. Full and empty are distinguished by `count` only, never by pointer equality.
- `sOut` holds its value while `sOut_valid && !sOut_ready`. When `sOut_valid` = 0, `sOut` is don't-care.
- The block applies no arithmetic to tokens. The data path is a pure copy of N bits.

## Timing
- Reset (`nrst` low, asynchronous): `wr_ptr` = `rd_ptr` = `count` = 0.
- Outputs in reset:
  - `sOut_valid` = 0.
  - `sIn_ready` = 1 once state is cleared; it is held 0 while `nrst` = 0.
  - `sOut` = 0, because the array is cleared.
- Reset asserted mid-operation discards all stored tokens immediately. No partial push or pop completes on that edge.
- Latency from push to visible on `sOut` when empty is 1 cycle.
- Sustained throughput is 1 token/cycle when `sOut_ready` = 1 constantly.
- Deassertion of `nrst` is synchronised externally. The first valid push is on the first rising edge with `nrst` = 1.

## Configuration
Macro: `STREAM_BUFFER_LEVEL_EN`.
- Defined: adds output `level` (width clog2(DEPTH)+1) equal to registered `count`, and output `full_seen`, a sticky flag. `full_seen` sets on any cycle where `count` == DEPTH and `sIn_valid` = 1, and clears only on reset. Both reset to 0.
- Undefined: neither port exists. The core behaviour above is identical.

## Structure
- Shared include, alongside existing stream macros:
  - `intN` default width.
  - `true`/`false`.
  - A `clog2`-based `BUF_AW(DEPTH)` width macro used for pointer and count sizing.
- Stream ports are declared with the existing `stream` port macros so the block instantiates with `in(stream,…)` and `out(stream,…)` like a primitive.
- One sub-module, `stream_buffer_mem`:
  - DEPTH×N register array with synchronous write port and asynchronous read port.
  - Async clear on `nrst`.
- Pointer and count control lives in `stream_buffer`.

## Test plan
- **Fill:** reset, then push 1,2,3,4 with `sOut_ready` = 0 (DEPTH = 4). Expect `sIn_ready` = 0 after the 4th push, `sOut` = 1 held, and `count` = 4.
- **Drain at full:** with `sOut_ready` = 1 and `sIn_valid` = 1 (`sIn` = 5) while full:
  - Cycle 1: pop of 1, no push.
  - Next cycle: `sIn_ready` = 1, push 5.
  - Output order 1,2,3,4,5.
- **Streaming:** push an incrementing `sIn` from 1 each cycle with `sOut_ready` = 1 for 20 cycles. Expect `sOut` to equal `sIn` delayed by 1 cycle, `count` ≤ 1, no gaps, and both pointers wrapping 5 times.
- **Empty pop:** `sOut_ready` = 1 and `sIn_valid` = 0 from reset. Expect `sOut_valid` = 0 and pointers stay at 0.
- **Reset mid-stream:** 3 tokens stored, pull `nrst` low between edges. Expect `sOut_valid` = 0 and `sIn_ready` = 0 immediately. After release, expect `sIn_ready` = 1 and the next push value is the first output.
- **Level option:** with `STREAM_BUFFER_LEVEL_EN`, the fill scenario gives `level` 1,2,3,4. An attempted 5th push sets `full_seen` = 1, which stays 1 after draining.

Source files
------------

// File: rtl/stream_buffer_pkg.sv
// Shared parameters and sizing helpers for the stream_buffer elastic FIFO.
package stream_buffer_pkg;

  localparam int unsigned DEFAULT_N     = 8;
  localparam int unsigned DEFAULT_DEPTH = 4;

  // Address width for a power-of-two DEPTH; count is one bit wider to reach DEPTH.
  function automatic int unsigned buf_aw(input int unsigned depth);
    return $clog2(depth);
  endfunction

endpackage

// File: rtl/stream_buffer_if.sv
// One valid/ready stream channel; master drives data/valid, slave drives ready.
interface stream_buffer_if #(
  parameter int unsigned N = 8
);

  logic [N-1:0] data;
  logic         valid;
  logic         ready;

  modport master (output data, output valid, input ready);
  modport slave  (input data, input valid, output ready);

endinterface

// File: rtl/stream_buffer_mem.sv
// DEPTH x N register array: synchronous write, asynchronous read, async clear.
module stream_buffer_mem
  import stream_buffer_pkg::*;
#(
  parameter int unsigned N     = DEFAULT_N,
  parameter int unsigned DEPTH = DEFAULT_DEPTH
) (
  input  logic                      clk,
  input  logic                      nrst,
  input  logic                      we,
  input  logic [buf_aw(DEPTH)-1:0]  waddr,
  input  logic [N-1:0]              wdata,
  input  logic [buf_aw(DEPTH)-1:0]  raddr,
  output logic [N-1:0]              rdata_c
);

  logic [N-1:0] mem [DEPTH];

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
    end else if (we) begin
      mem[waddr] <= wdata;
    end
  end

  // Head is visible without a register stage so a pushed token shows one cycle later.
  assign rdata_c = mem[raddr];

endmodule

// File: rtl/stream_buffer.sv
// Elastic valid/ready FIFO; tokens leave in arrival order, unmodified.
// Define STREAM_BUFFER_LEVEL_EN to add the level and full_seen outputs.
module stream_buffer
  import stream_buffer_pkg::*;
#(
  parameter int unsigned N     = DEFAULT_N,
  parameter int unsigned DEPTH = DEFAULT_DEPTH
) (
  input  logic            clk,
  input  logic            nrst,
  stream_buffer_if.slave  sIn,
  stream_buffer_if.master sOut
`ifdef STREAM_BUFFER_LEVEL_EN
  ,
  output logic [$clog2(DEPTH):0] level,
  output logic                   full_seen
`endif
);

  localparam int unsigned AW = buf_aw(DEPTH);
  localparam int unsigned CW = AW + 1;

  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [CW-1:0] count;
  logic          push_c;
  logic          pop_c;

  // Handshake flags decode from registered count only; ready is forced low in reset.
  assign sIn.ready  = nrst && (count != CW'(DEPTH));
  assign sOut.valid = (count != '0);
  assign push_c     = sIn.valid && sIn.ready;
  assign pop_c      = sOut.valid && sOut.ready;

  // Pointers wrap naturally at DEPTH; full vs empty is told apart by count alone.
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push_c) wr_ptr <= wr_ptr + AW'(1);
      if (pop_c)  rd_ptr <= rd_ptr + AW'(1);
      case ({push_c, pop_c})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  stream_buffer_mem #(
    .N     (N),
    .DEPTH (DEPTH)
  ) u_mem (
    .clk     (clk),
    .nrst    (nrst),
    .we      (push_c),
    .waddr   (wr_ptr),
    .wdata   (sIn.data),
    .raddr   (rd_ptr),
    .rdata_c (sOut.data)
  );

`ifdef STREAM_BUFFER_LEVEL_EN
  assign level = count;

  // Sticky: records any push attempt made against a full buffer.
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      full_seen <= 1'b0;
    end else if ((count == CW'(DEPTH)) && sIn.valid) begin
      full_seen <= 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_stream_buffer.sv
// Directed self-checking bench for stream_buffer (N=8, DEPTH=4).
module tb_stream_buffer;

  localparam int unsigned N     = 8;
  localparam int unsigned DEPTH = 4;

  logic clk;
  logic nrst;
  int   n_checks;
  int   n_fail;

  stream_buffer_if #(.N(N)) sin_if ();
  stream_buffer_if #(.N(N)) sout_if ();

`ifdef STREAM_BUFFER_LEVEL_EN
  logic [2:0] level;
  logic       full_seen;
`endif

  stream_buffer #(
    .N     (N),
    .DEPTH (DEPTH)
  ) dut (
    .clk       (clk),
    .nrst      (nrst),
    .sIn       (sin_if),
    .sOut      (sout_if)
`ifdef STREAM_BUFFER_LEVEL_EN
    ,
    .level     (level),
    .full_seen (full_seen)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    nrst = 1'b1;
    sin_if.valid = 1'b0;
    sin_if.data = '0;
    sout_if.ready = 1'b0;
    #1 nrst = 1'b0;
    tick();
    tick();
    n_checks++;
    if (sout_if.valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid: got %b expected 0", sout_if.valid); end
    n_checks++;
    if (sin_if.ready !== 1'b0) begin n_fail++; $display("FAIL reset_ready_held: got %b expected 0", sin_if.ready); end
    n_checks++;
    if (sout_if.data !== 8'h00) begin n_fail++; $display("FAIL reset_data: got %h expected 00", sout_if.data); end
    nrst = 1'b1;
    #1;
    n_checks++;
    if (sin_if.ready !== 1'b1) begin n_fail++; $display("FAIL reset_ready_release: got %b expected 1", sin_if.ready); end
    n_checks++;
    if (dut.count !== 3'd0) begin n_fail++; $display("FAIL reset_count: got %0d expected 0", dut.count); end
  endtask

  task automatic test_empty_pop();
    sout_if.ready = 1'b1;
    sin_if.valid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      n_checks++;
      if (sout_if.valid !== 1'b0) begin n_fail++; $display("FAIL empty_valid: got %b expected 0", sout_if.valid); end
      n_checks++;
      if (dut.rd_ptr !== 2'd0 || dut.wr_ptr !== 2'd0) begin
        n_fail++; $display("FAIL empty_ptrs: got rd=%0d wr=%0d expected 0 0", dut.rd_ptr, dut.wr_ptr);
      end
    end
  endtask

  task automatic test_fill();
    sout_if.ready = 1'b0;
    for (int i = 1; i <= 4; i++) begin
      sin_if.valid = 1'b1;
      sin_if.data = 8'(i);
      tick();
      n_checks++;
      if (dut.count !== 3'(i)) begin n_fail++; $display("FAIL fill_count: got %0d expected %0d", dut.count, i); end
      n_checks++;
      if (sout_if.valid !== 1'b1 || sout_if.data !== 8'd1) begin
        n_fail++; $display("FAIL fill_head_held: got v=%b d=%0d expected v=1 d=1", sout_if.valid, sout_if.data);
      end
      n_checks++;
      if (sin_if.ready !== (i < 4)) begin n_fail++; $display("FAIL fill_ready: got %b expected %b", sin_if.ready, (i < 4)); end
`ifdef STREAM_BUFFER_LEVEL_EN
      n_checks++;
      if (level !== 3'(i)) begin n_fail++; $display("FAIL fill_level: got %0d expected %0d", level, i); end
      n_checks++;
      if (full_seen !== 1'b0) begin n_fail++; $display("FAIL fill_full_seen: got %b expected 0", full_seen); end
`endif
    end
  endtask

  task automatic test_drain_full();
    logic [7:0] exp_data [5];
    logic [2:0] exp_cnt [5];
    exp_data = '{8'd1, 8'd2, 8'd3, 8'd4, 8'd5};
    exp_cnt  = '{3'd3, 3'd3, 3'd2, 3'd1, 3'd0};
    sin_if.valid = 1'b1;
    sin_if.data = 8'd5;
    sout_if.ready = 1'b1;
    #1;
    for (int k = 0; k < 5; k++) begin
      n_checks++;
      if (sout_if.valid !== 1'b1 || sout_if.data !== exp_data[k]) begin
        n_fail++; $display("FAIL drain_order[%0d]: got v=%b d=%0d expected v=1 d=%0d", k, sout_if.valid, sout_if.data, exp_data[k]);
      end
      if (k == 0) begin
        n_checks++;
        if (sin_if.ready !== 1'b0) begin n_fail++; $display("FAIL drain_ready_full: got %b expected 0", sin_if.ready); end
      end
      if (k == 1) begin
        n_checks++;
        if (sin_if.ready !== 1'b1) begin n_fail++; $display("FAIL drain_ready_reopen: got %b expected 1", sin_if.ready); end
      end
      tick();
      if (k == 1) sin_if.valid = 1'b0;
      n_checks++;
      if (dut.count !== exp_cnt[k]) begin n_fail++; $display("FAIL drain_count[%0d]: got %0d expected %0d", k, dut.count, exp_cnt[k]); end
    end
    n_checks++;
    if (sout_if.valid !== 1'b0) begin n_fail++; $display("FAIL drain_empty: got %b expected 0", sout_if.valid); end
`ifdef STREAM_BUFFER_LEVEL_EN
    n_checks++;
    if (full_seen !== 1'b1) begin n_fail++; $display("FAIL full_seen_sticky: got %b expected 1", full_seen); end
`endif
  endtask

  task automatic test_streaming();
    int wr_wraps;
    int rd_wraps;
    logic [1:0] pw;
    logic [1:0] pr;
    nrst = 1'b0;
    tick();
    nrst = 1'b1;
    wr_wraps = 0;
    rd_wraps = 0;
    pw = 2'd0;
    pr = 2'd0;
    sout_if.ready = 1'b1;
    for (int c = 0; c < 20; c++) begin
      sin_if.valid = 1'b1;
      sin_if.data = 8'(c + 1);
      tick();
      if (dut.wr_ptr == 2'd0 && pw != 2'd0) wr_wraps++;
      if (dut.rd_ptr == 2'd0 && pr != 2'd0) rd_wraps++;
      pw = dut.wr_ptr;
      pr = dut.rd_ptr;
      n_checks++;
      if (sout_if.valid !== 1'b1 || sout_if.data !== 8'(c + 1)) begin
        n_fail++; $display("FAIL stream_data[%0d]: got v=%b d=%0d expected v=1 d=%0d", c, sout_if.valid, sout_if.data, c + 1);
      end
      n_checks++;
      if (dut.count !== 3'd1) begin n_fail++; $display("FAIL stream_count[%0d]: got %0d expected 1", c, dut.count); end
    end
    sin_if.valid = 1'b0;
    tick();
    if (dut.rd_ptr == 2'd0 && pr != 2'd0) rd_wraps++;
    n_checks++;
    if (sout_if.valid !== 1'b0 || dut.count !== 3'd0) begin
      n_fail++; $display("FAIL stream_end: got v=%b cnt=%0d expected v=0 cnt=0", sout_if.valid, dut.count);
    end
    n_checks++;
    if (wr_wraps != 5 || rd_wraps != 5) begin
      n_fail++; $display("FAIL stream_wraps: got wr=%0d rd=%0d expected 5 5", wr_wraps, rd_wraps);
    end
  endtask

  task automatic test_reset_mid();
    sout_if.ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      sin_if.valid = 1'b1;
      sin_if.data = 8'(8'h10 + i);
      tick();
    end
    sin_if.valid = 1'b0;
    n_checks++;
    if (dut.count !== 3'd3) begin n_fail++; $display("FAIL mid_stored: got %0d expected 3", dut.count); end
    #2 nrst = 1'b0;
    #1;
    n_checks++;
    if (sout_if.valid !== 1'b0) begin n_fail++; $display("FAIL mid_reset_valid: got %b expected 0", sout_if.valid); end
    n_checks++;
    if (sin_if.ready !== 1'b0) begin n_fail++; $display("FAIL mid_reset_ready: got %b expected 0", sin_if.ready); end
    n_checks++;
    if (sout_if.data !== 8'h00 || dut.count !== 3'd0) begin
      n_fail++; $display("FAIL mid_reset_clear: got d=%h cnt=%0d expected 00 0", sout_if.data, dut.count);
    end
    tick();
    nrst = 1'b1;
    sin_if.valid = 1'b1;
    sin_if.data = 8'h77;
    sout_if.ready = 1'b1;
    #1;
    n_checks++;
    if (sin_if.ready !== 1'b1) begin n_fail++; $display("FAIL mid_release_ready: got %b expected 1", sin_if.ready); end
    tick();
    sin_if.valid = 1'b0;
    n_checks++;
    if (sout_if.valid !== 1'b1 || sout_if.data !== 8'h77) begin
      n_fail++; $display("FAIL mid_first_out: got v=%b d=%h expected v=1 d=77", sout_if.valid, sout_if.data);
    end
    tick();
    n_checks++;
    if (sout_if.valid !== 1'b0) begin n_fail++; $display("FAIL mid_final_empty: got %b expected 0", sout_if.valid); end
  endtask

  initial begin
    n_checks = 0;
    n_fail = 0;
    test_reset();
    test_empty_pop();
    test_fill();
    test_drain_full();
    test_streaming();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
